// File: rtl/mlp_fixed_pkg.sv
// mlp_fixed_pkg: shared Q4.16 fixed-point widths, PLAN sigmoid breakpoints/offsets and score type
package mlp_fixed_pkg;
    localparam int INT_W   = 4;
    localparam int FRAC_W  = 16;
    localparam int SCORE_W = INT_W + FRAC_W;
    localparam int MAG_W   = SCORE_W - 1;
    localparam int PROB_W  = FRAC_W + 1;
    localparam logic [MAG_W-1:0] BP_LO  = 19'h10000;
    localparam logic [MAG_W-1:0] BP_MID = 19'h26000;
    localparam logic [MAG_W-1:0] BP_HI  = 19'h50000;
    localparam logic [PROB_W-1:0] OFF_LO  = 17'h08000;
    localparam logic [PROB_W-1:0] OFF_MID = 17'h0A000;
    localparam logic [PROB_W-1:0] OFF_HI  = 17'h0D800;
    localparam logic [PROB_W-1:0] ONE     = 17'h10000;
    typedef logic signed [SCORE_W-1:0] score_t;
endpackage

// File: rtl/plan_sigmoid_seg.sv
// plan_sigmoid_seg: combinational PLAN sigmoid of a non-negative Q4.16 magnitude (segment select + shift-add)
module plan_sigmoid_seg
    import mlp_fixed_pkg::*;
(
    input  logic [MAG_W-1:0]  a,
    output logic [PROB_W-1:0] y
);
    // pick the segment by magnitude; shifted terms always fit in PROB_W so truncation is lossless
    always_comb begin
        y = (a >= BP_HI)  ? ONE :
            (a >= BP_MID) ? PROB_W'(a >> 5) + OFF_HI :
            (a >= BP_LO)  ? PROB_W'(a >> 3) + OFF_MID :
                            PROB_W'(a >> 2) + OFF_LO;
    end
endmodule

// File: rtl/mlp_output_classifier.sv
// mlp_output_classifier: 3-stage sigmoid/classify output stage; CLASSIFIER_COUNT_EN adds the pos_count counter
module mlp_output_classifier
    import mlp_fixed_pkg::*;
#(
    parameter int INTEGRAL_WIDTH = INT_W,
    parameter int FRACTION_WIDTH = FRAC_W,
    parameter logic signed [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] THRESHOLD = '0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [INTEGRAL_WIDTH+FRACTION_WIDTH-1:0] in_score,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [FRACTION_WIDTH:0]                out_prob,
    output logic                                   out_class
`ifdef CLASSIFIER_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0]                 pos_count
`endif
);
    localparam int SW = INTEGRAL_WIDTH + FRACTION_WIDTH;
    localparam int MW = SW - 1;
    localparam int PW = FRACTION_WIDTH + 1;

    logic          advance;
    logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic          sign1_q, sign1_d, cls1_q, cls1_d;
    logic [MW-1:0] a1_q, a1_d;
    logic          sign2_q, sign2_d, cls2_q, cls2_d;
    logic [PW-1:0] y2_q, y2_d, y_seg;
    logic [PW-1:0] out_prob_q, out_prob_d;
    logic          out_class_q, out_class_d;
    logic [SW-1:0] neg;
    logic          is_min;

    plan_sigmoid_seg u_seg (
        .a (a1_q),
        .y (y_seg)
    );

    assign advance   = !v3_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = v3_q;
    assign out_prob  = out_prob_q;
    assign out_class = out_class_q;
    assign neg       = SW'(0) - in_score;
    assign is_min    = in_score == {1'b1, {MW{1'b0}}};

    // next state of every stage; everything holds unless the pipeline advances
    always_comb begin
        v1_d        = v1_q;
        sign1_d     = sign1_q;
        cls1_d      = cls1_q;
        a1_d        = a1_q;
        v2_d        = v2_q;
        sign2_d     = sign2_q;
        cls2_d      = cls2_q;
        y2_d        = y2_q;
        v3_d        = v3_q;
        out_prob_d  = out_prob_q;
        out_class_d = out_class_q;
        if (advance) begin
            v1_d        = in_valid;
            sign1_d     = in_score[SW-1];
            cls1_d      = $signed(in_score) >= THRESHOLD;
            a1_d        = !in_score[SW-1] ? in_score[MW-1:0] : is_min ? '1 : neg[MW-1:0];
            v2_d        = v1_q;
            sign2_d     = sign1_q;
            cls2_d      = cls1_q;
            y2_d        = y_seg;
            v3_d        = v2_q;
            out_prob_d  = sign2_q ? ONE - y2_q : y2_q;
            out_class_d = cls2_q;
        end
    end

    // pipeline registers with synchronous reset discarding anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            sign1_q     <= 1'b0;
            cls1_q      <= 1'b0;
            a1_q        <= '0;
            v2_q        <= 1'b0;
            sign2_q     <= 1'b0;
            cls2_q      <= 1'b0;
            y2_q        <= '0;
            v3_q        <= 1'b0;
            out_prob_q  <= '0;
            out_class_q <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            sign1_q     <= sign1_d;
            cls1_q      <= cls1_d;
            a1_q        <= a1_d;
            v2_q        <= v2_d;
            sign2_q     <= sign2_d;
            cls2_q      <= cls2_d;
            y2_q        <= y2_d;
            v3_q        <= v3_d;
            out_prob_q  <= out_prob_d;
            out_class_q <= out_class_d;
        end
    end

`ifdef CLASSIFIER_COUNT_EN
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    assign pos_count = cnt_q;

    // count delivered positives, saturating at all-ones
    always_comb begin
        cnt_d = (v3_q && out_ready && out_class_q && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    // positive-class counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif
endmodule

// File: tb/tb_mlp_output_classifier.sv
// tb_mlp_output_classifier: directed table-driven bench for mlp_output_classifier (CLASSIFIER_COUNT_EN aware)
module tb_mlp_output_classifier;
  localparam int N = 13;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_class;
  logic [19:0] in_score;
  logic [16:0] out_prob;
`ifdef CLASSIFIER_COUNT_EN
  logic [CW-1:0] pos_count;
`endif
  typedef struct {
    logic [19:0] score;
    logic [16:0] prob;
    logic        cls;
  } vec_t;
  vec_t vt[N];
  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  always #5 clk = ~clk;
  mlp_output_classifier #(.COUNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_score  (in_score),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prob  (out_prob),
    .out_class (out_class)
`ifdef CLASSIFIER_COUNT_EN
    ,
    .pos_count (pos_count)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic count_handshake(input logic cls);
    if (cls && exp_cnt < (1 << CW) - 1) exp_cnt++;
  endtask
  task automatic chk_count(input string name);
`ifdef CLASSIFIER_COUNT_EN
    chk(name, 32'(pos_count), 32'(exp_cnt));
`endif
  endtask
  initial begin
    vt[0]  = '{20'h00000, 17'h08000, 1'b1};
    vt[1]  = '{20'h10000, 17'h0C000, 1'b1};
    vt[2]  = '{20'hF0000, 17'h04000, 1'b0};
    vt[3]  = '{20'h60000, 17'h10000, 1'b1};
    vt[4]  = '{20'h80000, 17'h00000, 1'b0};
    vt[5]  = '{20'h26000, 17'h0EB00, 1'b1};
    vt[6]  = '{20'h25FFF, 17'h0EBFF, 1'b1};
    vt[7]  = '{20'h4FFFF, 17'h0FFFF, 1'b1};
    vt[8]  = '{20'h50000, 17'h10000, 1'b1};
    vt[9]  = '{20'hFFFFF, 17'h08000, 1'b0};
    vt[10] = '{20'h08000, 17'h0A000, 1'b1};
    vt[11] = '{20'hD0000, 17'h01000, 1'b0};
    vt[12] = '{20'h0FFFF, 17'h0BFFF, 1'b1};
    rst = 1'b1; in_valid = 1'b0; in_score = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_prob", 32'(out_prob), 0);
    chk("rst_out_class", 32'(out_class), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk_count("rst_pos_count");
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_score = vt[i].score;
      chk("single_in_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk("single_lat1", 32'(out_valid), 0);
      tick();
      chk("single_lat2", 32'(out_valid), 0);
      tick();
      chk("single_lat3", 32'(out_valid), 1);
      chk($sformatf("single_prob[%0d]", i), 32'(out_prob), 32'(vt[i].prob));
      chk($sformatf("single_class[%0d]", i), 32'(out_class), 32'(vt[i].cls));
      count_handshake(vt[i].cls);
      tick();
      chk("single_drained", 32'(out_valid), 0);
      chk_count($sformatf("single_count[%0d]", i));
    end
    begin
      int idx_out = 0;
      for (int c = 0; c < N + 6; c++) begin
        in_valid = c < N;
        in_score = c < N ? vt[c].score : 20'h0;
        if (out_valid) begin
          chk("stream_slot", 32'(c), 32'(idx_out + 3));
          if (idx_out < N) begin
            chk($sformatf("stream_prob[%0d]", idx_out), 32'(out_prob), 32'(vt[idx_out].prob));
            chk($sformatf("stream_class[%0d]", idx_out), 32'(out_class), 32'(vt[idx_out].cls));
            count_handshake(vt[idx_out].cls);
          end
          idx_out++;
        end
        tick();
      end
      chk("stream_total", 32'(idx_out), 32'(N));
      chk_count("stream_count");
    end
    begin
      int acc = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
        in_valid = 1'b1;
        in_score = vt[acc].score;
        if (in_ready) acc++;
        tick();
      end
      chk("stall_accepted", 32'(acc), 3);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_prob", 32'(out_prob), 32'(vt[0].prob));
      in_valid = 1'b0;
      tick(); tick();
      chk("stall_hold_prob", 32'(out_prob), 32'(vt[0].prob));
      chk("stall_hold_class", 32'(out_class), 32'(vt[0].cls));
      chk_count("stall_no_count");
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        chk("release_valid", 32'(out_valid), 1);
        chk($sformatf("release_prob[%0d]", k), 32'(out_prob), 32'(vt[k].prob));
        chk($sformatf("release_class[%0d]", k), 32'(out_class), 32'(vt[k].cls));
        count_handshake(vt[k].cls);
        tick();
      end
      chk("release_done", 32'(out_valid), 0);
      chk_count("release_count");
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_score = vt[k + 3].score;
      tick();
    end
    in_valid = 1'b0;
    chk("rstall_full", 32'(out_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    chk("rstall_out_valid", 32'(out_valid), 0);
    chk("rstall_out_prob", 32'(out_prob), 0);
    chk("rstall_out_class", 32'(out_class), 0);
    chk("rstall_in_ready", 32'(in_ready), 1);
    chk_count("rstall_pos_count");
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rstall_no_stale", 32'(out_valid), 0);
    end
    chk_count("rstall_count_after");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mlp_output_classifier.md
Name: mlp_output_classifier

Overview:
- Final stage of the binary-classification MLP; sits directly downstream of the third (output) layer.
- Consumes the single signed fixed-point score from the output neuron and applies a pipelined piecewise-linear (PLAN) sigmoid approximation.
- Produces a probability, a hard class decision and a running positive-class count.
- Uses a valid/ready handshake on both sides so the score source and the result consumer can stall independently.

Parameters:
- INTEGRAL_WIDTH, 4: integer bits of the input score, sign included.
- FRACTION_WIDTH, 16: fraction bits of the input score and of the output probability.
- THRESHOLD, 0 (signed, INTEGRAL_WIDTH+FRACTION_WIDTH bits): class = 1 when score >= THRESHOLD.
- COUNT_WIDTH, 16: width of the positive-class counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active high.
- in_valid  in  1  in_score is valid.
- in_ready  out  1  stage accepts in_score this cycle.
- in_score  in  INTEGRAL_WIDTH+FRACTION_WIDTH  signed Q4.16 output-layer score.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_prob  out  FRACTION_WIDTH+1  unsigned Q1.16 sigmoid estimate, range 0x00000..0x10000.
- out_class  out  1  hard decision.
- pos_count  out  COUNT_WIDTH  positive results delivered (present only with CLASSIFIER_COUNT_EN).

Behaviour:
- Reset: one clk edge with rst=1 clears all stage valids, out_valid, out_prob, out_class and pos_count to 0. Data in flight is discarded; a reset mid-stall drops pending results.
- Pipeline: 3 stages, S1 to S3, with a global advance signal.
  - advance = !v3 || out_ready; in_ready = advance.
  - Input handshake is in_valid && in_ready. Output handshake is out_valid && out_ready.
- Latency: 3 cycles from input handshake to out_valid with no stall. Sustained throughput is 1 result per cycle.
- S1:
  - Register sign(in_score), class = (in_score >= THRESHOLD) as a signed compare, and a = |in_score|.
  - |most negative| (0x80000) saturates to 0x7FFFF.
- S2 computes y from a; segments are selected by a (Q4.16 breakpoints). Shifts are logical; results are truncated.
  - a >= 0x50000 (5.0): y = 0x10000.
  - 0x26000 <= a < 0x50000: y = (a>>5) + 0x0D800.
  - 0x10000 <= a < 0x26000: y = (a>>3) + 0x0A000.
  - a < 0x10000: y = (a>>2) + 0x08000.
- S3: out_prob = sign ? 0x10000 - y : y. out_class is carried from S1. Values hold while stalled.
- Stall: with out_valid=1 and out_ready=0, all stages hold and in_ready=0. No bubble collapse is required.
- pos_count:
  - Increments on each output handshake with out_class=1.
  - Saturates at all-ones and never wraps.
  - No increment while stalled.

Optional Feature:
- Macro CLASSIFIER_COUNT_EN.
- Defined: the pos_count port and counter exist as specified.
- Undefined: no counter logic and no pos_count port. All other behaviour is identical.

Decomposition:
- Shared package mlp_fixed_pkg holds:
  - Q-format widths.
  - Sigmoid breakpoints 0x10000, 0x26000, 0x50000.
  - Offsets 0x08000, 0x0A000, 0x0D800, and ONE = 0x10000.
  - The score typedef.
- One sub-module, plan_sigmoid_seg: combinational segment select plus shift-add for S2, reusable by hidden layers.

Test Plan:
- Score 0x00000, out_ready=1 -> after 3 cycles out_prob=0x08000, out_class=1; with macro, pos_count=1.
- Score 0x10000 (+1.0) -> out_prob=0x0C000, class=1.
- Score 0xF0000 (-1.0) -> out_prob=0x04000, class=0, pos_count unchanged.
- Score 0x60000 -> out_prob=0x10000, class=1.
- Score 0x80000 -> out_prob=0x00000, class=0, no overflow.
- out_ready=0, 5 back-to-back inputs -> exactly 3 accepted, then in_ready=0 and outputs stable. Raise out_ready -> results emerge in order, 1 per cycle.
- Assert rst during a stall -> next cycle out_valid=0, pos_count=0, and the pending results are never delivered.
- With the counter preset near all-ones -> pos_count saturates and does not wrap.
